uartprobe_axi_seq: RTL
======================

// Module: uartprobe_axi_seq
// PURPOSE
//  Sequences the uartprobe command byte stream so on-chip logic can issue whole AXI
//  accesses. One request {addr, data, write} becomes the probe byte sequence: address
//  bytes, then the read or write command, then the data byte. For a read, the block
//  collects the probe's one-byte reply. Sits between a requester and uartprobe rx/tx.
// PARAMETERS
//  ADDR_CACHE      1    1: skip address bytes equal to last-sent value; 0: always send all 4
//  TIMEOUT_CYCLES  256  max cycles in WAIT_RSP before read completes with timeout (>=1)
// PORTS
//  clk             in   1   clock, all logic on posedge
//  m_areset        in   1   reset, synchronous, active-high
//  req_valid       in   1   request valid
//  req_ready       out  1   request accepted when valid&&ready
//  req_write       in   1   1=AXI write, 0=AXI read
//  req_addr        in   32  AXI address
//  req_wdata       in   8   write data byte (ignored for reads)
//  rsp_valid       out  1   completion valid, held until rsp_ready
//  rsp_ready       in   1   completion consumed when valid&&ready
//  rsp_rdata       out  8   read byte; 0 for writes and timeouts
//  rsp_timeout     out  1   1: read got no reply within TIMEOUT_CYCLES
//  probe_rx_valid  out  1   byte to uartprobe rx_valid
//  probe_rx_data   out  8   byte to uartprobe rx_data
//  probe_rx_ready  in   1   from uartprobe rx_ready
//  probe_tx_valid  in   1   from uartprobe tx_valid
//  probe_tx_data   in   8   from uartprobe tx_data
//  probe_tx_ready  out  1   to uartprobe tx_ready
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1. State=IDLE, address cache invalid, counter 0.
//  Reset mid-transfer: probe_rx_valid=0 and rsp_valid=0 the next cycle; in-flight request dropped.
//  Command codes: AXI_WR0..3=0x12..0x15 (byte0=addr[7:0] .. byte3=addr[31:24]),
//   AXI_RD=0x16, AXI_WR=0x17.
//  States: IDLE -> ADDR_CMD -> ADDR_BYTE (loop over bytes 0..3) -> OP_CMD -> DATA_BYTE
//   (write only) | WAIT_RSP (read only) -> RESP -> IDLE.
//  IDLE: req_ready=1; latch req on handshake, req_ready=0 next cycle.
//  Byte out: probe_rx_valid/data registered; data stable while valid; transfer on
//   valid&&ready. Next byte presented the cycle after transfer, so 1 byte/cycle if ready held high.
//  Address: bytes 0..3 in order, each sent as WRn command then value.
//   ADDR_CACHE=1: skip byte n if cache valid and cache[n]==addr byte n.
//   Cache byte is updated when its value byte transfers.
//  Write: OP_CMD sends 0x17, DATA_BYTE sends req_wdata, then RESP (rdata=0, timeout=0).
//   No tx reply is awaited.
//  Read: OP_CMD sends 0x16, then WAIT_RSP: probe_tx_ready=1, counter cleared on entry.
//   First tx_valid&&tx_ready byte -> rsp_rdata, timeout=0, go to RESP.
//   Counter reaches TIMEOUT_CYCLES -> rdata=0, timeout=1, go to RESP.
//   Byte and timeout on the same cycle: the byte wins.
//  IDLE also holds probe_tx_ready=1; unsolicited or late bytes are discarded. In all
//   other states probe_tx_ready=0.
//  RESP: rsp_valid=1 with stable fields until rsp_ready; then IDLE, req_ready=1 next cycle.
//  Counter is 32-bit saturating; all address/data arithmetic is byte-select only.
// TESTING
//  1 reset held 3 cycles then released -> req_ready=1, all other outputs 0, no rx bytes.
//  2 write addr=0x12345678 data=0xA5, rx_ready=1 -> rx bytes 12 78 13 56 14 34 15 12 17 A5;
//    rsp_valid, timeout=0, rdata=0.
//  3 read addr=0x12345678 (cache hit), tx byte 0x3C after 5 cycles -> only 16 sent;
//    rdata=3C, timeout=0.
//  4 read addr=0x12345600 -> 12 00 16 sent; with ADDR_CACHE=0 all 8 address bytes precede 16.
//  5 read, TIMEOUT_CYCLES=16, no tx reply -> rsp after 16 cycles, timeout=1, rdata=0;
//    late 0x99 dropped; next read returns its own byte.
//  6 rx_ready random, rsp_ready low 10 cycles, reset mid-address -> data stable while valid;
//    rsp held; after reset the next write sends all 4 address bytes.

Source files
------------

// File: rtl/uartprobe_axi_seq.sv
// Turns one {addr, data, write} request into the uartprobe command byte stream
// and, for reads, collects the probe's one-byte reply (or times out).
module uartprobe_axi_seq #(
    parameter int ADDR_CACHE     = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        m_areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic        probe_rx_valid,
    output logic [7:0]  probe_rx_data,
    input  logic        probe_rx_ready,
    input  logic        probe_tx_valid,
    input  logic [7:0]  probe_tx_data,
    output logic        probe_tx_ready
);
    localparam logic [7:0] AXI_WR0 = 8'h12;
    localparam logic [7:0] AXI_RD  = 8'h16;
    localparam logic [7:0] AXI_WR  = 8'h17;

    typedef enum logic [2:0] {IDLE, ADDR_CMD, ADDR_BYTE, OP_CMD, DATA_BYTE, WAIT_RSP, RESP} state_t;

    state_t          state;
    logic [31:0]     addr_q;
    logic [7:0]      wdata_q;
    logic            write_q;
    logic [1:0]      idx;
    logic [3:0][7:0] cache;
    logic [3:0]      cache_vld;
    logic [31:0]     cnt;
    logic [3:0]      need_new, need_cur;
    logic [2:0]      nxt_new, nxt_cur;
    logic            rx_xfer;

    // Lowest set bit index; bit 2 of the result flags "none left".
    function automatic logic [2:0] first_set(input logic [3:0] m);
        first_set = 3'd4;
        for (int n = 3; n >= 0; n--)
            if (m[n]) first_set = 3'(n);
    endfunction

    always_comb begin
        need_new = '0;
        need_cur = '0;
        for (int n = 0; n < 4; n++) begin
            need_new[n] = (ADDR_CACHE == 0) || !cache_vld[n] || (cache[n] != req_addr[8*n +: 8]);
            need_cur[n] = (ADDR_CACHE == 0) || !cache_vld[n] || (cache[n] != addr_q[8*n +: 8]);
        end
        nxt_new = first_set(need_new);
        nxt_cur = first_set(need_cur & (4'b1110 << idx));
        rx_xfer = probe_rx_valid && probe_rx_ready;
    end

    always_ff @(posedge clk) begin
        if (m_areset) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 8'h00;
            rsp_timeout    <= 1'b0;
            probe_rx_valid <= 1'b0;
            probe_rx_data  <= 8'h00;
            probe_tx_ready <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            write_q        <= 1'b0;
            idx            <= '0;
            cache          <= '0;
            cache_vld      <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    probe_tx_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        addr_q         <= req_addr;
                        wdata_q        <= req_wdata;
                        write_q        <= req_write;
                        req_ready      <= 1'b0;
                        probe_tx_ready <= 1'b0;
                        probe_rx_valid <= 1'b1;
                        if (!nxt_new[2]) begin
                            state         <= ADDR_CMD;
                            idx           <= nxt_new[1:0];
                            probe_rx_data <= AXI_WR0 + {6'b0, nxt_new[1:0]};
                        end else begin
                            state         <= OP_CMD;
                            probe_rx_data <= req_write ? AXI_WR : AXI_RD;
                        end
                    end
                end
                ADDR_CMD: if (rx_xfer) begin
                    state         <= ADDR_BYTE;
                    probe_rx_data <= addr_q[{idx, 3'b000} +: 8];
                end
                ADDR_BYTE: if (rx_xfer) begin
                    // The cache only learns a byte once the probe has actually taken it.
                    cache[idx]     <= probe_rx_data;
                    cache_vld[idx] <= 1'b1;
                    if (!nxt_cur[2]) begin
                        state         <= ADDR_CMD;
                        idx           <= nxt_cur[1:0];
                        probe_rx_data <= AXI_WR0 + {6'b0, nxt_cur[1:0]};
                    end else begin
                        state         <= OP_CMD;
                        probe_rx_data <= write_q ? AXI_WR : AXI_RD;
                    end
                end
                OP_CMD: if (rx_xfer) begin
                    if (write_q) begin
                        state         <= DATA_BYTE;
                        probe_rx_data <= wdata_q;
                    end else begin
                        state          <= WAIT_RSP;
                        probe_rx_valid <= 1'b0;
                        probe_tx_ready <= 1'b1;
                        cnt            <= '0;
                    end
                end
                DATA_BYTE: if (rx_xfer) begin
                    state          <= RESP;
                    probe_rx_valid <= 1'b0;
                    rsp_valid      <= 1'b1;
                    rsp_rdata      <= 8'h00;
                    rsp_timeout    <= 1'b0;
                end
                WAIT_RSP: begin
                    // A reply arriving on the timeout cycle still counts as a reply.
                    if (probe_tx_valid) begin
                        state          <= RESP;
                        probe_tx_ready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= probe_tx_data;
                        rsp_timeout    <= 1'b0;
                    end else if (cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                        state          <= RESP;
                        probe_tx_ready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= 8'h00;
                        rsp_timeout    <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: if (rsp_ready) begin
                    state          <= IDLE;
                    rsp_valid      <= 1'b0;
                    req_ready      <= 1'b1;
                    probe_tx_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
